// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device frame transmitter started by a CPU bus write
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 2830,
  parameter int TIMEOUT_CYCLES = 56600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] bus_wraddr,
  input  logic [8:0]  bus_wrdata,
  input  logic        bus_wrvalid,
  output logic        bus_wrready,
  input  logic        ps2c_in,
  input  logic        ps2d_in,
  output logic        ps2c_oe,
  output logic        ps2d_oe,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAITREL} state_t;
  state_t state_q, state_d;
  logic [1:0] c_sync_q, d_sync_q;
  logic c_prev_q;
  logic [9:0] frame_q, frame_d;
  logic [3:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic d_oe_q, d_oe_d, done_q, done_d, err_q, err_d;
  logic c_s, d_s, fall, accept, expire;
  logic unused_bus;
  assign unused_bus = ^{bus_wraddr, bus_wrdata[8]};
  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];
  assign fall = c_prev_q & ~c_s;
  assign bus_wrready = state_q == IDLE;
  assign accept = bus_wrvalid & bus_wrready;
  assign busy = state_q != IDLE;
  assign ps2c_oe = state_q == INHIBIT || state_q == REQ;
  assign ps2d_oe = d_oe_q;
  assign done = done_q;
  assign err = err_q;
  // Synchronise the open-drain pins (idle high) and keep the previous clock sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      c_prev_q <= c_s;
    end
  end
  // Frame state register; reset drops both line drivers at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      d_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      d_oe_q <= d_oe_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // Sequence inhibit, start request, bit shifting on device clock falls, ack sampling and release wait
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d = idx_q;
    cnt_d = cnt_q - CW'(1);
    d_oe_d = d_oe_q;
    done_d = 1'b0;
    err_d = err_q;
    expire = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = INHIBIT;
        frame_d = {1'b1, ~^bus_wrdata[7:0], bus_wrdata[7:0]};
        err_d = 1'b0;
        cnt_d = INH_LD;
      end
      INHIBIT: if (cnt_q == '0) begin
        state_d = REQ;
        d_oe_d = 1'b1;
      end
      REQ: begin
        state_d = SHIFT;
        idx_d = '0;
        cnt_d = TO_LD;
      end
      SHIFT: if (fall) begin
        d_oe_d = ~frame_q[idx_q];
        idx_d = idx_q + 4'd1;
        cnt_d = TO_LD;
        state_d = idx_q == 4'd9 ? ACK : SHIFT;
      end else expire = cnt_q == '0;
      ACK: if (fall) begin
        err_d = err_q | d_s;
        state_d = WAITREL;
        cnt_d = TO_LD;
      end else expire = cnt_q == '0;
      WAITREL: if (c_s & d_s) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else if (fall) cnt_d = TO_LD;
      else expire = cnt_q == '0;
      default: state_d = IDLE;
    endcase
    if (expire) begin
      state_d = IDLE;
      d_oe_d = 1'b0;
      err_d = 1'b1;
      done_d = 1'b1;
    end
  end
endmodule
